mt_tc_bank: RTL
===============

// Module: mt_tc_bank
// PURPOSE
//   Parametrised MT Tape Control (TC) register for an NSLV-slave formatter.
//   Holds SS/EVPAR/FMT/DEN/UN11/EAODTE, muxes per-slave ACCL/FCS, and tracks
//   slave access change (SAC) with a settle interval. Refuses writes while a
//   function is in progress. Sits in the MT RH11/TM03 block beside the other
//   MT registers; mtTC feeds the register read mux.
// PARAMETERS
//   NSLV       8   number of slaves, 1..8; SS field stays 3 bits
//   SETTLE     16  cycles ACCL/FCS are masked after a slave change, >=1
//   DEN_PRESET 2   DEN value loaded by read-in preset
// PORTS
//   clk        in   1     clock
//   rst_n      in   1     reset, asynchronous, active-low
//   mtINIT     in   1     sync initialise, same effect as reset
//   mtDATAI    in   36    write data; TC layout in [15:0], [16] = select-only
//   mtWRTC     in   1     write strobe, one cycle
//   mtPRESET   in   1     read-in preset strobe
//   mtBUSY     in   1     function in progress; TC writes refused
//   mtSACCLR   in   1     clear SAC, one cycle
//   mtACCL     in   NSLV  per-slave accelerate status
//   mtFCS      in   NSLV  per-slave frame count status
//   mtTC       out  16    {ACCL,FCS,SAC,EAODTE,UN11,DEN[2:0],FMT[3:0],EVPAR,SS[2:0]}
//   mtSWBUSY   out  1     high during settle interval
//   mtRMR      out  1     one-cycle pulse: write refused (register modify refused)
// BEHAVIOUR
//   Reset (rst_n low or mtINIT): all stored fields 0, SAC 0, FSM IDLE, cnt 0,
//     mtSWBUSY 0, mtRMR 0. mtTC[15:14] follow slave 0 inputs.
//   Accepted write = mtWRTC & !mtBUSY & !mtPRESET. Write with mtBUSY: no field
//     changes, mtRMR=1 next cycle. Normal write loads all fields from [12:0].
//   ACCL/FCS: combinational mtACCL[SS]/mtFCS[SS]; forced 0 if SS>=NSLV or
//     FSM in SETTLE. Read-only; write data bits [15:13] ignored.
//   SAC: set on the cycle after an accepted write whose SS differs from the
//     stored SS. Cleared only by reset, mtINIT, mtSACCLR. Set wins over mtSACCLR.
//   PRESET: DEN<=DEN_PRESET, FMT<=0, EVPAR<=0, SS<=0; UN11/EAODTE kept;
//     not blocked by mtBUSY; beats same-cycle mtWRTC (write dropped, no mtRMR);
//     never sets SAC; enters SETTLE if previous SS!=0.
//   FSM: IDLE -> SETTLE on any SS change (write or preset), cnt<=SETTLE-1.
//     SETTLE: cnt decrements; SETTLE->IDLE when cnt==0. Another SS change in
//     SETTLE reloads cnt. mtSWBUSY = (state==SETTLE). Latency: write at cycle
//     T -> mtTC.SS and mtSWBUSY valid T+1, ACCL/FCS unmasked at T+1+SETTLE.
//   Writes in SETTLE are accepted; same-SS writes do not restart the count.
// CONFIGURATION
//   MTTC_CTX_EN defined: per-slave shadow {DEN,FMT,EVPAR} (8 bits x NSLV).
//     Every accepted normal write also updates shadow[new SS]. Accepted write
//     with mtDATAI[16]=1 is select-only: SS loaded from [2:0], DEN/FMT/EVPAR
//     restored from shadow[SS], UN11/EAODTE unchanged. SAC/SETTLE rules as
//     normal. SS>=NSLV restores 0. PRESET loads shadow[0] with DEN_PRESET/0/0,
//     leaves other shadows. Reset clears all shadows.
//   Undefined: no shadows; mtDATAI[16] ignored, every write is normal.
// TESTING
//   1 reset, write 16'o017777 -> SS=7,EVPAR=1,FMT=17,DEN=7,UN11=1,EAODTE=1,
//     SAC=1, mtSWBUSY high exactly SETTLE cycles, ACCL/FCS 0 meanwhile.
//   2 mtBUSY=1, write SS=3 -> mtTC unchanged, mtRMR one pulse, SAC stays 0.
//   3 SS=2, mtACCL=8'h04,mtFCS=8'h00 after settle -> mtTC[15:14]=2'b10; NSLV=2
//     build, write SS=5 -> mtTC[15:14]=0.
//   4 mtWRTC+mtPRESET same cycle from SS=4 -> DEN=2,FMT=0,SS=0,SAC unchanged,
//     mtSWBUSY asserted, no mtRMR; write SS=1 then SS=2 mid-settle -> count
//     restarts, total busy = cycles to 2nd write + SETTLE.
//   5 SAC=1, mtSACCLR with write changing SS same cycle -> SAC=1; mtSACCLR
//     alone -> SAC=0; rst_n low mid-SETTLE -> all 0 immediately, IDLE.
//   6 MTTC_CTX_EN: write SS=1,DEN=4,FMT=2; write SS=3,DEN=1; select-only SS=1
//     -> DEN=4,FMT=2,SS=1; without macro same sequence -> DEN=0,FMT=0 (bit16
//     ignored, data fields loaded).

Source files
------------

// File: rtl/mt_tc_bank_if.sv
// MT Tape Control register bus bundle.
// Master drives strobes/data/status, slave returns mtTC and flags.
interface mt_tc_bank_if #(
    parameter int NSLV = 8
);
    logic            mtINIT;
    logic [35:0]     mtDATAI;
    logic            mtWRTC;
    logic            mtPRESET;
    logic            mtBUSY;
    logic            mtSACCLR;
    logic [NSLV-1:0] mtACCL;
    logic [NSLV-1:0] mtFCS;
    logic [15:0]     mtTC;
    logic            mtSWBUSY;
    logic            mtRMR;

    modport master (
        output mtINIT, mtDATAI, mtWRTC, mtPRESET,
        output mtBUSY, mtSACCLR, mtACCL, mtFCS,
        input  mtTC, mtSWBUSY, mtRMR
    );

    modport slave (
        input  mtINIT, mtDATAI, mtWRTC, mtPRESET,
        input  mtBUSY, mtSACCLR, mtACCL, mtFCS,
        output mtTC, mtSWBUSY, mtRMR
    );
endinterface

// File: rtl/mt_tc_bank.sv
// MT Tape Control register with slave-select settle tracking.
// Define MTTC_CTX_EN for per-slave DEN/FMT/EVPAR shadows.
module mt_tc_bank #(
    parameter int NSLV       = 8,
    parameter int SETTLE     = 16,
    parameter int DEN_PRESET = 2
) (
    input logic         clk,
    input logic         rst_n,
    mt_tc_bank_if.slave bus
);

    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE - 1);

    typedef enum logic {
        ST_IDLE,
        ST_SETTLE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [2:0] ss_q, ss_d;
    logic       evpar_q, evpar_d;
    logic [3:0] fmt_q, fmt_d;
    logic [2:0] den_q, den_d;
    logic       un11_q, un11_d;
    logic       eaodte_q, eaodte_d;
    logic       sac_q, sac_d;
    logic       rmr_q, rmr_d;

    logic       wr_acc;
    logic       ss_chg;
    logic [2:0] wr_ss;
    logic       accl;
    logic       fcs;

`ifdef MTTC_CTX_EN
    logic [7:0] shd_q [NSLV];
    logic [7:0] shd_d [NSLV];
    logic [7:0] rest;
    logic       unused_data;
    assign unused_data = ^{bus.mtDATAI[35:17], bus.mtDATAI[15:13]};
`else
    logic       unused_data;
    assign unused_data = ^{bus.mtDATAI[35:13]};
`endif

    // Field update: init, preset, accepted write (normal or select-only)
    always_comb begin
        ss_d     = ss_q;
        evpar_d  = evpar_q;
        fmt_d    = fmt_q;
        den_d    = den_q;
        un11_d   = un11_q;
        eaodte_d = eaodte_q;
        sac_d    = sac_q;
        rmr_d    = 1'b0;
        ss_chg   = 1'b0;
        wr_ss    = bus.mtDATAI[2:0];
        wr_acc   = bus.mtWRTC & ~bus.mtBUSY & ~bus.mtPRESET;
`ifdef MTTC_CTX_EN
        shd_d = shd_q;
        rest  = '0;
        for (int i = 0; i < NSLV; i++) begin
            if (wr_ss == 3'(i)) begin
                rest = shd_q[i];
            end
        end
`endif
        if (bus.mtINIT) begin
            ss_d     = '0;
            evpar_d  = 1'b0;
            fmt_d    = '0;
            den_d    = '0;
            un11_d   = 1'b0;
            eaodte_d = 1'b0;
            sac_d    = 1'b0;
`ifdef MTTC_CTX_EN
            for (int i = 0; i < NSLV; i++) begin
                shd_d[i] = '0;
            end
`endif
        end else begin
            rmr_d = bus.mtWRTC & bus.mtBUSY & ~bus.mtPRESET;
            if (bus.mtSACCLR) begin
                sac_d = 1'b0;
            end
            if (bus.mtPRESET) begin
                ss_chg  = (ss_q != 3'd0);
                ss_d    = '0;
                den_d   = 3'(DEN_PRESET);
                fmt_d   = '0;
                evpar_d = 1'b0;
`ifdef MTTC_CTX_EN
                shd_d[0] = {3'(DEN_PRESET), 5'd0};
`endif
            end else if (wr_acc) begin
                ss_chg = (wr_ss != ss_q);
                if (ss_chg) begin
                    sac_d = 1'b1;
                end
                ss_d = wr_ss;
`ifdef MTTC_CTX_EN
                if (bus.mtDATAI[16]) begin
                    {den_d, fmt_d, evpar_d} = rest;
                end else begin
                    {den_d, fmt_d, evpar_d} = bus.mtDATAI[10:3];
                    un11_d   = bus.mtDATAI[11];
                    eaodte_d = bus.mtDATAI[12];
                    for (int i = 0; i < NSLV; i++) begin
                        if (wr_ss == 3'(i)) begin
                            shd_d[i] = bus.mtDATAI[10:3];
                        end
                    end
                end
`else
                {den_d, fmt_d, evpar_d} = bus.mtDATAI[10:3];
                un11_d   = bus.mtDATAI[11];
                eaodte_d = bus.mtDATAI[12];
`endif
            end
        end
    end

    // Settle FSM: any slave change (re)starts the masking interval
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (bus.mtINIT) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else if (ss_chg) begin
            state_d = ST_SETTLE;
            cnt_d   = CNT_LOAD;
        end else if (state_q == ST_SETTLE) begin
            if (cnt_q == '0) begin
                state_d = ST_IDLE;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    // Selected slave status, masked while settling or out of range
    always_comb begin
        accl = 1'b0;
        fcs  = 1'b0;
        for (int i = 0; i < NSLV; i++) begin
            if (ss_q == 3'(i)) begin
                accl = bus.mtACCL[i];
                fcs  = bus.mtFCS[i];
            end
        end
        if (state_q == ST_SETTLE) begin
            accl = 1'b0;
            fcs  = 1'b0;
        end
    end

    assign bus.mtTC = {accl, fcs, sac_q, eaodte_q, un11_q,
                       den_q, fmt_q, evpar_q, ss_q};
    assign bus.mtSWBUSY = (state_q == ST_SETTLE);
    assign bus.mtRMR    = rmr_q;

    // Register state with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            ss_q     <= '0;
            evpar_q  <= 1'b0;
            fmt_q    <= '0;
            den_q    <= '0;
            un11_q   <= 1'b0;
            eaodte_q <= 1'b0;
            sac_q    <= 1'b0;
            rmr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ss_q     <= ss_d;
            evpar_q  <= evpar_d;
            fmt_q    <= fmt_d;
            den_q    <= den_d;
            un11_q   <= un11_d;
            eaodte_q <= eaodte_d;
            sac_q    <= sac_d;
            rmr_q    <= rmr_d;
        end
    end

`ifdef MTTC_CTX_EN
    // Per-slave context shadows
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NSLV; i++) begin
                shd_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NSLV; i++) begin
                shd_q[i] <= shd_d[i];
            end
        end
    end
`endif

endmodule
